// File: rtl/dom_pkg.sv
// Shared definitions for the DOM share boundary: LFSR constants and the mask-pool FSM states.
package dom_pkg;
   localparam int          LFSR_W       = 32;
   localparam logic [31:0] LFSR_TAPS    = 32'h8020_0003;
   localparam logic [31:0] DEFAULT_SEED = 32'hACE1_2468;

   typedef enum logic {
      FILL = 1'b0,
      FULL = 1'b1
   } mask_state_t;

   // Right-shifting Galois step; the taps are folded in when bit 0 falls out.
   function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
      return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
   endfunction
endpackage

// File: rtl/dom_mask_prng.sv
// Fresh-mask source: a 32-bit LFSR that fills a WIDTH-bit mask pool, one word per cycle.
//  state | meaning
//  FILL  | shifting LFSR words into the pool, cnt counts words loaded
//  FULL  | pool holds an unused mask, waiting for consume
module dom_mask_prng
   import dom_pkg::*;
#(
   parameter int          WIDTH = 128,
   parameter logic [31:0] SEED  = DEFAULT_SEED
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             seed_load,
   input  logic [31:0]      seed_in,
   input  logic             consume,
   output logic [WIDTH-1:0] mask,
   output logic             mask_full
);
   localparam int NW    = WIDTH / 32;
   localparam int CNT_W = (NW > 1) ? $clog2(NW) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NW - 1);

   mask_state_t         state;
   logic [CNT_W-1:0]    cnt;
   logic [LFSR_W-1:0]   lfsr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr  <= SEED;
         mask  <= '0;
         state <= FILL;
         cnt   <= '0;
      end else if (seed_load) begin
         // A consume in this cycle has already taken the old mask; the pool is refilled from the new seed.
         lfsr  <= (seed_in == 32'h0) ? SEED : seed_in;
         state <= FILL;
         cnt   <= '0;
      end else begin
         case (state)
            FILL: begin
               mask <= WIDTH'({mask, lfsr});
               lfsr <= lfsr_step(lfsr);
               if (cnt == CNT_LAST) begin
                  state <= FULL;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            FULL: begin
               if (consume) begin
                  state <= FILL;
                  cnt   <= '0;
               end
            end
            default: state <= FILL;
         endcase
      end
   end

   assign mask_full = (state == FULL);
endmodule

// File: rtl/dom_share_codec.sv
// Boundary between the unmasked AES I/O and the 2-share DOM datapath:
// splits words into (d ^ m, m) with single-use masks and recombines output shares after a register.
module dom_share_codec
   import dom_pkg::*;
#(
   parameter int          WIDTH = 128,
   parameter logic [31:0] SEED  = 32'hACE1_2468
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             seed_load,
   input  logic [31:0]      seed_in,
   input  logic             enc_in_valid,
   output logic             enc_in_ready,
   input  logic [WIDTH-1:0] enc_in_data,
   output logic             enc_out_valid,
   input  logic             enc_out_ready,
   output logic [WIDTH-1:0] enc_sh0,
   output logic [WIDTH-1:0] enc_sh1,
   input  logic             dec_in_valid,
   output logic             dec_in_ready,
   input  logic [WIDTH-1:0] dec_sh0,
   input  logic [WIDTH-1:0] dec_sh1,
   output logic             dec_out_valid,
   input  logic             dec_out_ready,
   output logic [WIDTH-1:0] dec_out_data
);
   logic [WIDTH-1:0] mask;
   logic             mask_full;
   logic             enc_acc;
   logic             dec_acc;
   logic             rst_done;
   logic [WIDTH-1:0] dec_s0_q;
   logic [WIDTH-1:0] dec_s1_q;

   dom_mask_prng #(.WIDTH(WIDTH), .SEED(SEED)) u_prng (
      .clk       (clk),
      .rst_n     (rst_n),
      .seed_load (seed_load),
      .seed_in   (seed_in),
      .consume   (enc_acc),
      .mask      (mask),
      .mask_full (mask_full)
   );

   assign enc_in_ready = mask_full && !seed_load && (!enc_out_valid || enc_out_ready);
   assign enc_acc      = enc_in_valid && enc_in_ready;
   // rst_done keeps dec_in_ready low while reset is asserted.
   assign dec_in_ready = rst_done && (!dec_out_valid || dec_out_ready);
   assign dec_acc      = dec_in_valid && dec_in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_done      <= 1'b0;
         enc_out_valid <= 1'b0;
         enc_sh0       <= '0;
         enc_sh1       <= '0;
         dec_out_valid <= 1'b0;
         dec_s0_q      <= '0;
         dec_s1_q      <= '0;
      end else begin
         rst_done <= 1'b1;
         if (enc_acc) begin
            enc_sh0       <= enc_in_data ^ mask;
            enc_sh1       <= mask;
            enc_out_valid <= 1'b1;
         end else if (enc_out_ready) begin
            enc_out_valid <= 1'b0;
         end
         if (dec_acc) begin
            dec_s0_q      <= dec_sh0;
            dec_s1_q      <= dec_sh1;
            dec_out_valid <= 1'b1;
         end else if (dec_out_ready) begin
            dec_out_valid <= 1'b0;
         end
      end
   end

   // Shares are registered separately so the unmasked value only exists after the barrier.
   assign dec_out_data = dec_s0_q ^ dec_s1_q;
endmodule

// File: tb/tb_dom_share_codec.sv
// Directed bench for dom_share_codec at WIDTH=64: vector tables plus handshake/seed/reset sequences.
module tb_dom_share_codec;
   localparam int          W    = 64;
   localparam logic [31:0] SEED = 32'hACE1_2468;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          seed_load = 1'b0;
   logic [31:0]   seed_in = '0;
   logic          enc_in_valid = 1'b0;
   logic          enc_in_ready;
   logic [W-1:0]  enc_in_data = '0;
   logic          enc_out_valid;
   logic          enc_out_ready = 1'b1;
   logic [W-1:0]  enc_sh0, enc_sh1;
   logic          dec_in_valid = 1'b0;
   logic          dec_in_ready;
   logic [W-1:0]  dec_sh0 = '0, dec_sh1 = '0;
   logic          dec_out_valid;
   logic          dec_out_ready = 1'b1;
   logic [W-1:0]  dec_out_data;

   int n_cmp = 0;
   int n_bad = 0;
   logic [31:0] m_lfsr;

   always #5 clk = ~clk;

   dom_share_codec #(.WIDTH(W), .SEED(SEED)) dut (
      .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed_in(seed_in),
      .enc_in_valid(enc_in_valid), .enc_in_ready(enc_in_ready), .enc_in_data(enc_in_data),
      .enc_out_valid(enc_out_valid), .enc_out_ready(enc_out_ready),
      .enc_sh0(enc_sh0), .enc_sh1(enc_sh1),
      .dec_in_valid(dec_in_valid), .dec_in_ready(dec_in_ready),
      .dec_sh0(dec_sh0), .dec_sh1(dec_sh1),
      .dec_out_valid(dec_out_valid), .dec_out_ready(dec_out_ready), .dec_out_data(dec_out_data)
   );

   typedef struct {
      logic [W-1:0] s0;
      logic [W-1:0] s1;
      logic [W-1:0] exp;
   } dvec_t;

   function automatic logic [31:0] gstep(input logic [31:0] s);
      logic [31:0] t;
      t = {1'b0, s[31:1]};
      if (s[0]) t = t ^ 32'h8020_0003;
      return t;
   endfunction

   // Next mask the pool will present: two consecutive LFSR states, oldest in the upper word.
   task automatic next_mask(output logic [W-1:0] m);
      logic [31:0] hi;
      hi     = m_lfsr;
      m_lfsr = gstep(m_lfsr);
      m      = {hi, m_lfsr};
      m_lfsr = gstep(m_lfsr);
   endtask

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_enc_rdy(input string nm);
      for (int k = 0; k < 20 && !enc_in_ready; k++) tick();
      if (!enc_in_ready) chk({nm, " ready timeout"}, 64'(enc_in_ready), 64'd1);
   endtask

   task automatic encode(input string nm, input logic [W-1:0] d, output logic [W-1:0] sh1);
      logic [W-1:0] m;
      wait_enc_rdy(nm);
      next_mask(m);
      enc_in_valid = 1'b1;
      enc_in_data  = d;
      tick();
      enc_in_valid = 1'b0;
      chk({nm, " valid"}, 64'(enc_out_valid), 64'd1);
      chk({nm, " recombine"}, enc_sh0 ^ enc_sh1, d);
      chk({nm, " mask"}, enc_sh1, m);
      sh1 = enc_sh1;
   endtask

   task automatic load_seed(input logic [31:0] s);
      repeat (3) tick();
      seed_load = 1'b1;
      seed_in   = s;
      #1;
      chk("seed gates ready", 64'(enc_in_ready), 64'd0);
      tick();
      seed_load = 1'b0;
      m_lfsr    = (s == 32'h0) ? SEED : s;
   endtask

   dvec_t        dv[5];
   logic [W-1:0] ev[3];
   logic [W-1:0] sa[3], sb[3];
   logic [W-1:0] r0, tmp, hs0, hs1, hd, mo;

   initial begin
      dv[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0};
      dv[1] = '{64'h0123_4567_89AB_CDEF, 64'h0, 64'h0123_4567_89AB_CDEF};
      dv[2] = '{64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 64'hFFFF_FFFF_FFFF_FFFF};
      dv[3] = '{64'hDEAD_BEEF_CAFE_F00D, 64'hDEAD_BEEF_CAFE_F00D, 64'h0};
      dv[4] = '{64'h1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001};
      ev[0] = 64'h0123_4567_89AB_CDEF;
      ev[1] = 64'hFEDC_BA98_7654_3210;
      ev[2] = 64'h0;

      // 1: reset values, then ready timing after release
      repeat (3) @(posedge clk);
      #1;
      chk("rst enc_in_ready", 64'(enc_in_ready), 64'd0);
      chk("rst dec_in_ready", 64'(dec_in_ready), 64'd0);
      chk("rst enc_out_valid", 64'(enc_out_valid), 64'd0);
      chk("rst dec_out_valid", 64'(dec_out_valid), 64'd0);
      chk("rst enc_sh0", enc_sh0, 64'h0);
      chk("rst enc_sh1", enc_sh1, 64'h0);
      chk("rst dec_out_data", dec_out_data, 64'h0);
      rst_n  = 1'b1;
      m_lfsr = SEED;
      tick();
      chk("clk1 enc_in_ready", 64'(enc_in_ready), 64'd0);
      chk("clk1 dec_in_ready", 64'(dec_in_ready), 64'd1);
      tick();
      chk("clk2 enc_in_ready", 64'(enc_in_ready), 64'd1);

      // 2: first encode, then the refill gap
      encode("enc0", ev[0], r0);
      chk("enc0 mask nonzero", 64'(r0 != 64'h0), 64'd1);
      chk("gap c0", 64'(enc_in_ready), 64'd0);
      tick();
      chk("gap c1", 64'(enc_in_ready), 64'd0);
      tick();
      chk("gap c2", 64'(enc_in_ready), 64'd1);
      for (int i = 1; i < 3; i++) encode("enc tbl", ev[i], tmp);

      // 3: decoder table, back-to-back
      for (int i = 0; i < 5; i++) begin
         dec_in_valid = 1'b1;
         dec_sh0 = dv[i].s0;
         dec_sh1 = dv[i].s1;
         #1;
         chk("dec in_ready", 64'(dec_in_ready), 64'd1);
         tick();
         chk("dec valid", 64'(dec_out_valid), 64'd1);
         chk("dec data", dec_out_data, dv[i].exp);
      end
      dec_in_valid = 1'b0;
      tick();
      chk("dec drain", 64'(dec_out_valid), 64'd0);

      // 4: backpressure on both sides
      wait_enc_rdy("bp");
      next_mask(mo);
      enc_out_ready = 1'b0;
      dec_out_ready = 1'b0;
      enc_in_valid  = 1'b1;
      enc_in_data   = 64'h1122_3344_5566_7788;
      dec_in_valid  = 1'b1;
      dec_sh0 = 64'h00FF_00FF_00FF_00FF;
      dec_sh1 = 64'h0F0F_0F0F_F0F0_F0F0;
      tick();
      enc_in_valid = 1'b0;
      dec_in_valid = 1'b0;
      hs0 = 64'h1122_3344_5566_7788 ^ mo;
      hs1 = mo;
      hd  = 64'h0FF0_0FF0_F00F_F00F;
      for (int i = 0; i < 5; i++) begin
         chk("hold enc valid", 64'(enc_out_valid), 64'd1);
         chk("hold sh0", enc_sh0, hs0);
         chk("hold sh1", enc_sh1, hs1);
         chk("hold dec valid", 64'(dec_out_valid), 64'd1);
         chk("hold dec data", dec_out_data, hd);
         chk("hold enc_in_ready", 64'(enc_in_ready), 64'd0);
         chk("hold dec_in_ready", 64'(dec_in_ready), 64'd0);
         tick();
      end
      enc_out_ready = 1'b1;
      dec_out_ready = 1'b1;
      #1;
      chk("release sh0", enc_sh0, hs0);
      chk("release dec data", dec_out_data, hd);
      chk("release dec_in_ready", 64'(dec_in_ready), 64'd1);
      tick();
      chk("release enc valid", 64'(enc_out_valid), 64'd0);
      chk("release dec valid", 64'(dec_out_valid), 64'd0);

      // 5: seed reloads repeat the mask sequence
      load_seed(32'h1);
      for (int i = 0; i < 3; i++) encode("seed1a", ev[i], sa[i]);
      load_seed(32'h1);
      for (int i = 0; i < 3; i++) encode("seed1b", ev[i], sb[i]);
      for (int i = 0; i < 3; i++) chk("seed1 repeat", sb[i], sa[i]);
      load_seed(32'h0);
      encode("seed0", ev[0], tmp);
      chk("seed0 equals reset", tmp, r0);

      // 6: reseed right behind an accept, then reset while shares are pending
      wait_enc_rdy("reseed");
      next_mask(mo);
      enc_in_valid = 1'b1;
      enc_in_data  = 64'hCAFE_BABE_0000_FFFF;
      tick();
      enc_in_valid = 1'b0;
      chk("reseed old mask", enc_sh1, mo);
      chk("reseed data", enc_sh0 ^ enc_sh1, 64'hCAFE_BABE_0000_FFFF);
      seed_load = 1'b1;
      seed_in   = 32'h5;
      tick();
      seed_load = 1'b0;
      m_lfsr    = 32'h5;
      chk("reseed r0", 64'(enc_in_ready), 64'd0);
      tick();
      chk("reseed r1", 64'(enc_in_ready), 64'd0);
      tick();
      chk("reseed r2", 64'(enc_in_ready), 64'd1);
      encode("reseed new", ev[1], tmp);

      wait_enc_rdy("rst");
      enc_out_ready = 1'b0;
      enc_in_valid  = 1'b1;
      enc_in_data   = 64'h55AA;
      tick();
      enc_in_valid = 1'b0;
      chk("pre-rst valid", 64'(enc_out_valid), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("rst enc valid drop", 64'(enc_out_valid), 64'd0);
      chk("rst sh0 clear", enc_sh0, 64'h0);
      chk("rst enc_in_ready drop", 64'(enc_in_ready), 64'd0);
      chk("rst dec_in_ready drop", 64'(dec_in_ready), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
